// File: rtl/gf163_pkg.sv
// Shared constants for the GF(2^163) digit-serial multiplier datapath.
package gf163_pkg;

  localparam int unsigned M       = 163;
  localparam int unsigned D       = 16;
  localparam int unsigned NUM_DIG = 11;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SR_W    = NUM_DIG * D;

  // x^163 + x^7 + x^6 + x^3 + 1, leading term implicit
  localparam logic [M-1:0] G_POLY = M'(8'hC9);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FEED = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/b_digit_feeder_if.sv
// Operand-in / digit-out bundle between the feeder and its neighbours.
// SQUARE_MODE_EN adds the sq select.
interface b_digit_feeder_if;
  import gf163_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
`ifdef SQUARE_MODE_EN
  logic         sq;
`endif
  logic [M-1:0] a_out;
  logic [M-1:0] g_out;
  logic [D-1:0] b_digit;
  logic         dig_valid;
  logic         dig_ready;
  logic         dig_first;
  logic         dig_last;
  logic         res_capture;

  // feeder side
  modport master (
`ifdef SQUARE_MODE_EN
    input  sq,
`endif
    input  in_valid, a_in, b_in, dig_ready,
    output in_ready, a_out, g_out, b_digit, dig_valid, dig_first, dig_last, res_capture
  );

  // operand source / PE array side
  modport slave (
`ifdef SQUARE_MODE_EN
    output sq,
`endif
    output in_valid, a_in, b_in, dig_ready,
    input  in_ready, a_out, g_out, b_digit, dig_valid, dig_first, dig_last, res_capture
  );

endinterface

// File: rtl/b_digit_shreg.sv
// Load/shift register presenting its top D bits as the current B digit.
module b_digit_shreg
  import gf163_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            shift_en,
  input  logic [SR_W-1:0] load_val,
  output logic [D-1:0]    window
);

  logic [SR_W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_val;
    end else if (shift_en) begin
      sr_q <= {sr_q[SR_W-D-1:0], D'(0)};
    end
  end

  assign window = sr_q[SR_W-1 -: D];

endmodule

// File: rtl/b_digit_feeder.sv
// Operand sequencer: latches A, streams B MSB-first as D-bit digits, pulses res_capture.
// Optional SQUARE_MODE_EN: sq=1 at accept streams A instead of B.
module b_digit_feeder
  import gf163_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  b_digit_feeder_if.master bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     a_q;
  logic             in_ready_q, in_ready_d;
  logic             dig_valid_q, dig_valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             cap_q, cap_d;
  logic             accept_c;
  logic             beat_c;
  logic [M-1:0]     b_src_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign beat_c   = (state_q == ST_FEED) & bus.dig_ready;

`ifdef SQUARE_MODE_EN
  assign b_src_c = bus.sq ? bus.a_in : bus.b_in;
`else
  assign b_src_c = bus.b_in;
`endif

  // Next state, digit counter and next values of the registered flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_FEED;
          cnt_d   = '0;
        end
      end
      ST_FEED: begin
        if (cnt_q > CNT_W'(NUM_DIG - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (beat_c) begin
          if (cnt_q == CNT_W'(NUM_DIG - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    dig_valid_d = (state_d == ST_FEED);
    first_d     = (state_d == ST_FEED) && (cnt_d == '0);
    last_d      = (state_d == ST_FEED) && (cnt_d == CNT_W'(NUM_DIG - 1));
    cap_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      dig_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      cap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      dig_valid_q <= dig_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      cap_q       <= cap_d;
    end
  end

  // A is held from one accept to the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
    end else if (accept_c) begin
      a_q <= bus.a_in;
    end
  end

  b_digit_shreg u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_c),
    .shift_en (beat_c),
    .load_val (SR_W'(b_src_c)),
    .window   (bus.b_digit)
  );

  assign bus.in_ready    = in_ready_q;
  assign bus.a_out       = a_q;
  assign bus.g_out       = G_POLY;
  assign bus.dig_valid   = dig_valid_q;
  assign bus.dig_first   = first_q;
  assign bus.dig_last    = last_q;
  assign bus.res_capture = cap_q;

endmodule
